font_row_reader: RTL and testbench

Glyph fetch engine that drives the `font` ROM's pixel-address side and collects its serial `data` bit stream into whole glyph rows.
- A character code is accepted through a valid/ready request port.
- The block scans the 8×8 cell (pos_x 0..7 per row, pos_y 0..7), compensating for ROM read latency.
- It delivers eight 8-bit row bytes, top row first, through a valid/ready output port.
- It sits between the font ROM and consumers that need packed glyph bytes (text-mode framebuffer fill, sprite/blitter loaders).

---
 rtl/font_row_reader.sv | 135 +++++++++++++
 tb/tb_font_row_reader.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/font_row_reader.sv
// rtl/font_row_reader.sv - glyph fetch engine packing serial font ROM bits into row bytes
module font_row_reader #(
    parameter int ROM_LAT = 1,
    parameter int GLYPH_H = 8
) (
    input  logic       px_clk,
    input  logic       resetn,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [7:0] req_char,
    output logic [9:0] font_pos_x,
    output logic [9:0] font_pos_y,
    output logic [7:0] font_char,
    input  logic       font_data,
    output logic       row_valid,
    input  logic       row_ready,
    output logic [7:0] row_data,
    output logic [2:0] row_idx,
    output logic       row_last,
    output logic       busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [7:0]         char_q, char_d;
    logic [2:0]         row_q, row_d;
    logic [2:0]         issue_q, issue_d;
    logic               iss_done_q, iss_done_d;
    logic [2:0]         cap_q, cap_d;
    logic [ROM_LAT-1:0] pipe_q, pipe_d;
    logic [7:0]         data_q, data_d;
    logic               issue_v;

    // State and datapath registers; reset discards any partial glyph.
    always_ff @(posedge px_clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            char_q     <= '0;
            row_q      <= '0;
            issue_q    <= '0;
            iss_done_q <= 1'b0;
            cap_q      <= '0;
            pipe_q     <= '0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            char_q     <= char_d;
            row_q      <= row_d;
            issue_q    <= issue_d;
            iss_done_q <= iss_done_d;
            cap_q      <= cap_d;
            pipe_q     <= pipe_d;
            data_q     <= data_d;
        end
    end

    // Next-state logic: address issue, latency-matched capture and row handshake.
    always_comb begin
        state_d    = state_q;
        char_d     = char_q;
        row_d      = row_q;
        issue_d    = issue_q;
        iss_done_d = iss_done_q;
        cap_d      = cap_q;
        data_d     = data_q;
        issue_v    = 1'b0;
        pipe_d     = pipe_q << 1;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    state_d    = S_SCAN;
                    char_d     = req_char;
                    row_d      = '0;
                    issue_d    = '0;
                    iss_done_d = 1'b0;
                    cap_d      = '0;
                    pipe_d     = '0;
                end
            end
            S_SCAN: begin
                // Each issued address launches a token that emerges when its bit arrives.
                issue_v = !iss_done_q;
                if (issue_v) begin
                    if (issue_q == 3'd7) begin
                        iss_done_d = 1'b1;
                    end else begin
                        issue_d = issue_q + 3'd1;
                    end
                end
                pipe_d = (pipe_q << 1) | ROM_LAT'(issue_v);
                if (pipe_q[ROM_LAT-1]) begin
                    data_d[3'd7 - cap_q] = font_data;
                    cap_d                = cap_q + 3'd1;
                    if (cap_q == 3'd7) begin
                        state_d = S_OUT;
                    end
                end
            end
            S_OUT: begin
                if (row_ready) begin
                    if (row_q == 3'(GLYPH_H - 1)) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d    = S_SCAN;
                        row_d      = row_q + 3'd1;
                        issue_d    = '0;
                        iss_done_d = 1'b0;
                        cap_d      = '0;
                        pipe_d     = '0;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign req_ready  = (state_q == S_IDLE);
    assign busy       = (state_q != S_IDLE);
    assign row_valid  = (state_q == S_OUT);
    assign row_last   = (state_q == S_OUT) && (row_q == 3'(GLYPH_H - 1));
    assign row_data   = data_q;
    assign row_idx    = row_q;
    assign font_char  = char_q;
    assign font_pos_x = {7'd0, issue_q};
    assign font_pos_y = {7'd0, row_q};

endmodule

// File: tb/tb_font_row_reader.sv
// tb/tb_font_row_reader.sv - self-checking bench for font_row_reader
`timescale 1ns/1ps
module tb_font_row_reader;

    logic px_clk = 1'b0;
    logic resetn = 1'b0;
    always #5 px_clk = ~px_clk;

    int cyc = 0;
    always @(posedge px_clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    // instance a: ROM_LAT=1, GLYPH_H=8
    logic       req_valid, req_ready, font_data, row_valid, row_ready, row_last, busy;
    logic [7:0] req_char, font_char, row_data;
    logic [9:0] font_pos_x, font_pos_y;
    logic [2:0] row_idx;
    // instance b: ROM_LAT=3, GLYPH_H=8
    logic       b_req_valid, b_req_ready, b_font_data, b_row_valid, b_row_ready, b_row_last, b_busy;
    logic [7:0] b_req_char, b_font_char, b_row_data;
    logic [9:0] b_font_pos_x, b_font_pos_y;
    logic [2:0] b_row_idx;
    // instance c: ROM_LAT=1, GLYPH_H=1
    logic       c_req_valid, c_req_ready, c_font_data, c_row_valid, c_row_ready, c_row_last, c_busy;
    logic [7:0] c_req_char, c_font_char, c_row_data;
    logic [9:0] c_font_pos_x, c_font_pos_y;
    logic [2:0] c_row_idx;

    font_row_reader #(.ROM_LAT(1), .GLYPH_H(8)) u_dut (
        .px_clk(px_clk), .resetn(resetn), .req_valid(req_valid), .req_ready(req_ready),
        .req_char(req_char), .font_pos_x(font_pos_x), .font_pos_y(font_pos_y),
        .font_char(font_char), .font_data(font_data), .row_valid(row_valid),
        .row_ready(row_ready), .row_data(row_data), .row_idx(row_idx),
        .row_last(row_last), .busy(busy));

    font_row_reader #(.ROM_LAT(3), .GLYPH_H(8)) u_dut_lat3 (
        .px_clk(px_clk), .resetn(resetn), .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_char(b_req_char), .font_pos_x(b_font_pos_x), .font_pos_y(b_font_pos_y),
        .font_char(b_font_char), .font_data(b_font_data), .row_valid(b_row_valid),
        .row_ready(b_row_ready), .row_data(b_row_data), .row_idx(b_row_idx),
        .row_last(b_row_last), .busy(b_busy));

    font_row_reader #(.ROM_LAT(1), .GLYPH_H(1)) u_dut_h1 (
        .px_clk(px_clk), .resetn(resetn), .req_valid(c_req_valid), .req_ready(c_req_ready),
        .req_char(c_req_char), .font_pos_x(c_font_pos_x), .font_pos_y(c_font_pos_y),
        .font_char(c_font_char), .font_data(c_font_data), .row_valid(c_row_valid),
        .row_ready(c_row_ready), .row_data(c_row_data), .row_idx(c_row_idx),
        .row_last(c_row_last), .busy(c_busy));

    // stub font ROM: bit (7 - x) of (char ^ y), delayed ROM_LAT cycles
    function automatic logic rom_bit(input logic [7:0] ch, input logic [9:0] x, input logic [9:0] y);
        logic [7:0] v;
        v = ch ^ y[7:0];
        return v[3'd7 - x[2:0]];
    endfunction

    logic       rom_a_q = 1'b0;
    logic [2:0] rom_b_q = 3'd0;
    logic       rom_c_q = 1'b0;
    always @(posedge px_clk) begin
        rom_a_q <= rom_bit(font_char, font_pos_x, font_pos_y);
        rom_b_q <= {rom_b_q[1:0], rom_bit(b_font_char, b_font_pos_x, b_font_pos_y)};
        rom_c_q <= rom_bit(c_font_char, c_font_pos_x, c_font_pos_y);
    end
    assign font_data   = rom_a_q;
    assign b_font_data = rom_b_q[2];
    assign c_font_data = rom_c_q;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // scoreboards
    typedef struct packed {
        logic [7:0] data;
        logic [2:0] idx;
        logic       last;
    } row_t;
    row_t sb_a[$];
    row_t sb_b[$];
    row_t sb_c[$];
    row_t ea, eb, ec;

    task automatic push_glyph(input int which, input logic [7:0] ch, input int h);
        row_t r;
        for (int i = 0; i < h; i++) begin
            r.data = ch ^ 8'(i);
            r.idx  = 3'(i);
            r.last = (i == h - 1);
            if (which == 0) sb_a.push_back(r);
            else if (which == 1) sb_b.push_back(r);
            else sb_c.push_back(r);
        end
    endtask

    initial forever begin
        @(negedge px_clk);
        if (resetn && row_valid && row_ready) begin
            if (sb_a.size() == 0) begin
                check("a_unexpected_row", 1, 0);
            end else begin
                ea = sb_a.pop_front();
                check("a_row_data", row_data, ea.data);
                check("a_row_idx", row_idx, ea.idx);
                check("a_row_last", row_last, ea.last);
            end
        end
    end

    int b_last_pop = -1;
    initial forever begin
        @(negedge px_clk);
        if (resetn && b_row_valid && b_row_ready) begin
            if (b_last_pop >= 0) check("b_row_period", cyc - b_last_pop, 12);
            b_last_pop = cyc;
            if (sb_b.size() == 0) begin
                check("b_unexpected_row", 1, 0);
            end else begin
                eb = sb_b.pop_front();
                check("b_row_data", b_row_data, eb.data);
                check("b_row_idx", b_row_idx, eb.idx);
                check("b_row_last", b_row_last, eb.last);
            end
        end
    end

    initial forever begin
        @(negedge px_clk);
        if (resetn && c_row_valid && c_row_ready) begin
            if (sb_c.size() == 0) begin
                check("c_unexpected_row", 1, 0);
            end else begin
                ec = sb_c.pop_front();
                check("c_row_data", c_row_data, ec.data);
                check("c_row_idx", c_row_idx, ec.idx);
                check("c_row_last", c_row_last, ec.last);
            end
        end
    end

    function automatic logic cond(input int kind);
        case (kind)
            0: return row_valid;
            1: return row_valid && row_last;
            2: return req_ready;
            3: return row_valid && (row_idx == 3'd3);
            4: return row_valid && (row_idx == 3'd1);
            5: return b_row_valid;
            6: return b_req_ready;
            7: return c_row_valid;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_until(input int kind, input string name);
        int k;
        k = 0;
        while (!cond(kind) && k < 400) begin
            @(posedge px_clk);
            #1;
            k++;
        end
        check(name, cond(kind), 1);
    endtask

    task automatic send_a(input logic [7:0] ch, output int t0);
        @(negedge px_clk);
        check("a_ready_before_req", req_ready, 1);
        req_valid = 1'b1;
        req_char  = ch;
        @(posedge px_clk);
        #1;
        t0        = cyc;
        req_valid = 1'b0;
        req_char  = ~ch;
    endtask

    typedef struct {
        logic [7:0] ch;
        logic [7:0] row0;
        logic [7:0] row7;
        int         first_lat;
        int         done_lat;
    } vec_t;

    initial begin
        vec_t vecs[3];
        int   t0;

        vecs[0] = '{8'h37, 8'h37, 8'h30, 9, 80};
        vecs[1] = '{8'hC3, 8'hC3, 8'hC4, 9, 80};
        vecs[2] = '{8'h00, 8'h00, 8'h07, 9, 80};

        req_valid = 0; req_char = 0; row_ready = 1;
        b_req_valid = 0; b_req_char = 0; b_row_ready = 1;
        c_req_valid = 0; c_req_char = 0; c_row_ready = 1;

        repeat (3) @(posedge px_clk);
        #1;
        check("rst_req_ready", req_ready, 1);
        check("rst_row_valid", row_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_row_data", row_data, 0);
        check("rst_row_idx", row_idx, 0);
        check("rst_row_last", row_last, 0);
        check("rst_font_pos_x", font_pos_x, 0);
        check("rst_font_pos_y", font_pos_y, 0);
        check("rst_font_char", font_char, 0);
        @(negedge px_clk);
        resetn = 1'b1;

        // basic fetches, row_ready held high
        for (int i = 0; i < 3; i++) begin
            send_a(vecs[i].ch, t0);
            push_glyph(0, vecs[i].ch, 8);
            check("a_pos_x_after_accept", font_pos_x, 0);
            check("a_pos_y_after_accept", font_pos_y, 0);
            check("a_font_char_latched", font_char, vecs[i].ch);
            check("a_busy_after_accept", {busy, req_ready}, 2'b10);
            wait_until(0, "a_wait_first_row");
            check("a_first_row_latency", cyc - t0, vecs[i].first_lat);
            check("a_first_row_data", row_data, vecs[i].row0);
            wait_until(1, "a_wait_last_row");
            check("a_last_row_data", row_data, vecs[i].row7);
            wait_until(2, "a_wait_idle");
            check("a_glyph_latency", cyc - t0, vecs[i].done_lat);
        end

        // backpressure on row 3 of 8'h41
        send_a(8'h41, t0);
        push_glyph(0, 8'h41, 8);
        wait_until(3, "bp_wait_row3");
        row_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge px_clk);
            #1;
            check("bp_row_valid", row_valid, 1);
            check("bp_row_data", row_data, 8'h42);
            check("bp_row_idx", row_idx, 3);
            check("bp_pos_x", font_pos_x, 7);
            check("bp_pos_y", font_pos_y, 3);
        end
        row_ready = 1'b1;
        wait_until(2, "bp_wait_idle");

        // request while busy is ignored until the glyph completes
        send_a(8'h37, t0);
        push_glyph(0, 8'h37, 8);
        repeat (3) @(posedge px_clk);
        #1;
        req_valid = 1'b1;
        req_char  = 8'h55;
        check("busy_req_char_kept", font_char, 8'h37);
        wait_until(2, "busy_wait_idle");
        check("busy_idle_latency", cyc - t0, 80);
        push_glyph(0, 8'h55, 8);
        @(posedge px_clk);
        #1;
        req_valid = 1'b0;
        check("busy_second_accept", {busy, font_char}, {1'b1, 8'h55});
        wait_until(2, "busy_wait_idle2");

        // reset in the middle of row 2
        send_a(8'h37, t0);
        push_glyph(0, 8'h37, 8);
        wait_until(4, "rst_wait_row1");
        repeat (3) @(posedge px_clk);
        #1;
        resetn = 1'b0;
        #1;
        check("midrst_row_valid", row_valid, 0);
        check("midrst_row_data", row_data, 0);
        check("midrst_row_idx", row_idx, 0);
        check("midrst_busy", busy, 0);
        check("midrst_req_ready", req_ready, 1);
        check("midrst_pos_x", font_pos_x, 0);
        check("midrst_font_char", font_char, 0);
        sb_a.delete();
        @(negedge px_clk);
        resetn    = 1'b1;
        req_valid = 1'b1;
        req_char  = 8'h00;
        @(posedge px_clk);
        #1;
        t0        = cyc;
        req_valid = 1'b0;
        check("midrst_accept_first_edge", busy, 1);
        push_glyph(0, 8'h00, 8);
        wait_until(0, "midrst_wait_first_row");
        check("midrst_first_latency", cyc - t0, 9);
        wait_until(2, "midrst_wait_idle");

        // ROM_LAT=3
        @(negedge px_clk);
        b_req_valid = 1'b1;
        b_req_char  = 8'hA5;
        @(posedge px_clk);
        #1;
        t0          = cyc;
        b_req_valid = 1'b0;
        push_glyph(1, 8'hA5, 8);
        wait_until(5, "lat3_wait_first_row");
        check("lat3_first_latency", cyc - t0, 11);
        wait_until(6, "lat3_wait_idle");
        check("lat3_glyph_latency", cyc - t0, 96);

        // GLYPH_H=1
        @(negedge px_clk);
        c_req_valid = 1'b1;
        c_req_char  = 8'hFF;
        @(posedge px_clk);
        #1;
        t0          = cyc;
        c_req_valid = 1'b0;
        push_glyph(2, 8'hFF, 1);
        wait_until(7, "h1_wait_row");
        check("h1_first_latency", cyc - t0, 9);
        check("h1_row_last", c_row_last, 1);
        @(posedge px_clk);
        #1;
        check("h1_back_idle", {c_req_ready, c_busy}, 2'b10);

        repeat (3) @(posedge px_clk);
        check("sb_a_drained", sb_a.size(), 0);
        check("sb_b_drained", sb_b.size(), 0);
        check("sb_c_drained", sb_c.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
